// File: rtl/magic_subtractor.sv
// Purpose : recovers the unknown operand of a gray/binary magic adder (diff = sum - a)
// Latency : 2 cycles from input presentation to out_valid (two register stages)
// Backpressure: valid/ready both sides; in_ready = !v1 || S2 loads, combinational from out_ready only
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake for {sum, a, is_gray}
//   sum [W:0], a [W-1:0]  operands, both gray-coded when is_gray = 1
//   out_valid/out_ready   output handshake for {diff, err, out_is_gray}
//   diff [W-1:0]          recovered operand in the beat's code; 0 when err
//   err                   result below 0 or above 2^W-1
//   err_count [7:0]       saturating count of err beats transferred out
//
// Optional feature macro: MAGIC_SUB_ERRCNT_EN (builds the error counter; otherwise err_count = 0)

module magic_subtractor #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sum,
  input  logic [W-1:0] a,
  input  logic         is_gray,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         out_is_gray,
  output logic         err,
  output logic [7:0]   err_count
);

  // Gray decode: b[msb] = g[msb], each lower bit folds in the decoded bit above it.
  function automatic logic [W:0] sum_to_bin(input logic [W:0] g);
    logic [W:0] b;
    b[W] = g[W];
    for (int i = W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] op_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage 1: decoded operands
  logic         s1_vld;
  logic [W:0]   s1_sum;
  logic [W-1:0] s1_a;
  logic         s1_gray;

  // Stage 2: result register, drives the outputs directly
  logic         s2_vld;
  logic [W-1:0] s2_diff;
  logic         s2_err;
  logic         s2_gray;

  logic         s2_load;
  logic         s1_load;

  assign s2_load  = !s2_vld || out_ready;
  assign s1_load  = !s1_vld || s2_load;
  assign in_ready = s1_load;

  // Subtraction at W+2 bits so both underflow and overflow are visible.
  logic [W+1:0] d_full;
  logic [W-1:0] d_lo;
  logic [W-1:0] d_enc;
  logic         d_err;

  assign d_full = {1'b0, s1_sum} - {2'b00, s1_a};
  assign d_lo   = d_full[W-1:0];
  assign d_enc  = s1_gray ? (d_lo ^ (d_lo >> 1)) : d_lo;
  // Sign bit set means d < 0; bit W set on a non-negative d means d > 2^W-1.
  assign d_err  = d_full[W+1] | d_full[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sum  <= '0;
      s1_a    <= '0;
      s1_gray <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_sum  <= is_gray ? sum_to_bin(sum) : sum;
        s1_a    <= is_gray ? op_to_bin(a) : a;
        s1_gray <= is_gray;
      end
    end
  end

  // Result data only moves when a real beat arrives, so a held beat never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_diff <= '0;
      s2_err  <= 1'b0;
      s2_gray <= 1'b0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_diff <= d_err ? '0 : d_enc;
        s2_err  <= d_err;
        s2_gray <= s1_gray;
      end
    end
  end

  assign out_valid   = s2_vld;
  assign diff        = s2_diff;
  assign err         = s2_err;
  assign out_is_gray = s2_gray;

`ifdef MAGIC_SUB_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (s2_vld && out_ready && s2_err && (err_cnt_q != 8'd255)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_magic_subtractor.sv
// Purpose : directed and random-stream checks of magic_subtractor (W = 3)
// Latency : n/a (bench)
// Backpressure: bench drives out_ready directly, including stall and reset-in-flight cases

module tb_magic_subtractor;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum = '0;
  logic [W-1:0] a = '0;
  logic         is_gray = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         out_is_gray;
  logic         err;
  logic [7:0]   err_count;

  int total = 0;
  int bad = 0;
  int exp_errs = 0;

  logic [W-1:0] exp_d [16];
  logic         exp_e [16];
  logic         exp_g [16];

  magic_subtractor #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sum         (sum),
    .a           (a),
    .is_gray     (is_gray),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .out_is_gray (out_is_gray),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef MAGIC_SUB_ERRCNT_EN
    return (exp_errs > 255) ? 255 : exp_errs;
`else
    return 0;
`endif
  endfunction

  // Reference: gray decode written as XOR of all bits at or above i.
  function automatic void model(input logic [W:0] s, input logic [W-1:0] aa, input logic g,
                                output logic [W-1:0] d, output logic e);
    int sb;
    int ab;
    int dd;
    logic [W-1:0] t;
    sb = 0;
    ab = 0;
    if (g) begin
      for (int i = 0; i <= W; i++) sb[i] = ^(s >> i);
      for (int i = 0; i < W; i++) ab[i] = ^(aa >> i);
    end else begin
      sb = int'(s);
      ab = int'(aa);
    end
    dd = sb - ab;
    e = (dd < 0) || (dd > (1 << W) - 1);
    if (e) begin
      d = '0;
    end else begin
      t = dd[W-1:0];
      d = g ? (t ^ (t >> 1)) : t;
    end
  endfunction

  task automatic drive(input logic [W:0] s, input logic [W-1:0] aa, input logic g);
    in_valid = 1'b1;
    sum      = s;
    a        = aa;
    is_gray  = g;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d, input logic e, input logic g);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_diff"}, diff, d);
    chk({tag, "_err"}, err, e);
    chk({tag, "_gray"}, out_is_gray, g);
  endtask

  // One beat through an empty pipe with out_ready = 1; starts and ends at a negedge.
  task automatic single(input string tag, input logic [W:0] s, input logic [W-1:0] aa,
                        input logic g, input logic [W-1:0] d, input logic e);
    drive(s, aa, g);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_out(tag, d, e, g);
    if (e) exp_errs++;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [W:0]   rs;
    logic [W-1:0] ra;
    logic         rg;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_out_is_gray", out_is_gray, 1'b0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    single("bin", 4'd10, 3'b011, 1'b0, 3'b111, 1'b0);
    single("gray", 4'b1101, 3'b110, 1'b1, 3'b111, 1'b0);
    single("err_neg", 4'd2, 3'd5, 1'b0, 3'd0, 1'b1);
    single("err_big", 4'd15, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("errcnt_two", err_count, exp_cnt());
    single("zero", 4'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    single("max", 4'd12, 3'd5, 1'b0, 3'd7, 1'b0);

    // Backpressure: two beats fill the pipe, the third stalls.
    out_ready = 1'b0;
    drive(4'd10, 3'd3, 1'b0);
    #1 chk("bp_rdy0", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'd9, 3'd4, 1'b0);
    #1 chk("bp_rdy1", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(4'd7, 3'd7, 1'b0);
    #1 chk("bp_rdy2", in_ready, 1'b0);
    check_out("bp_hold0", 3'd7, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rdy3", in_ready, 1'b0);
    check_out("bp_hold1", 3'd7, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_out1", 3'd5, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_out("bp_out2", 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", out_valid, 1'b0);

    // Streaming: 16 back-to-back beats, results must follow with no bubbles.
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        check_out($sformatf("stream%0d", c - 2), exp_d[c-2], exp_e[c-2], exp_g[c-2]);
        if (exp_e[c-2]) exp_errs++;
      end
      if (c < 16) begin
        rs = W'(0) + 4'($urandom_range(0, 15));
        ra = 3'($urandom_range(0, 7));
        rg = 1'($urandom_range(0, 1));
        model(rs, ra, rg, exp_d[c], exp_e[c]);
        exp_g[c] = rg;
        drive(rs, ra, rg);
        #1 chk($sformatf("stream_rdy%0d", c), in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("stream_end", out_valid, 1'b0);
    chk("stream_errcnt", err_count, exp_cnt());

    // 300 error beats drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive(4'd15, 3'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    exp_errs += 300;
    chk("errcnt_sat", err_count, exp_cnt());

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive(4'd6, 3'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4'd5, 3'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    #2 rst_n = 1'b1;
    exp_errs  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("mid_stale%0d", i), out_valid, 1'b0);
    end
    single("post_rst", 4'd6, 3'd2, 1'b0, 3'd4, 1'b0);
    chk("final_errcnt", err_count, exp_cnt());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/magic_subtractor.md
# magic_subtractor

Inverse of the gray/binary magic adder: it takes a (W+1)-bit sum and one W-bit operand, both in the same code (binary or gray), and recovers the other operand. It sits on the receive side of the adder datapath and checks or reconstructs operands from stored sums. It is a two-stage pipeline with valid/ready handshakes on both sides. Out-of-range results raise an error flag.

## Interface
- W, default 3 — operand width; the sum is W+1 bits.
- clk  input  1  — rising-edge clock.
- rst_n  input  1  — asynchronous active-low reset.
- in_valid  input  1  — the input beat is valid.
- in_ready  output  1  — the block accepts the beat this cycle.
- sum  input  W+1  — sum word, in binary or gray per is_gray.
- a  input  W  — known operand, same code as sum.
- is_gray  input  1  — 1: sum and a are gray-coded, and diff is returned in gray.
- out_valid  output  1  — result beat is valid.
- out_ready  input  1  — downstream consumes the beat this cycle.
- diff  output  W  — recovered operand (sum − a), in the code of its beat.
- out_is_gray  output  1  — is_gray carried with the beat.
- err  output  1  — result out of range; diff forced to 0.
- err_count  output  8  — saturating error count (see Configuration).

## Operation
- Stage 1 (S1) register, loaded on an accepted input:
  - sum_b = gray_to_bin(sum) if is_gray, else sum.
  - a_b = gray_to_bin(a) if is_gray, else a.
  - is_gray is registered with them.
- Gray decode rule: b[msb] = g[msb]; b[i] = b[i+1] ^ g[i].
- Stage 2 (S2) register:
  - d = sum_b − a_b, computed at W+2 bits, signed.
  - err = (d < 0) || (d > 2^W − 1).
  - If err, diff = 0.
  - Otherwise diff = d[W-1:0], re-encoded as d ^ (d >> 1) when the beat is gray.
- Handshake: a transfer occurs when valid && ready at a rising edge.
  - Holding rule: once out_valid is high, diff, err and out_is_gray stay stable until the transfer.
  - in_valid may be held high while in_ready is low; the beat is not taken until in_ready is high.
- Load rules:
  - S2 loads when !v2 || out_ready.
  - S1 loads when !v1 || (S2 loads).
  - in_ready = !v1 || (S2 loads). This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Valid-bit updates:
  - v1 takes in_valid when S1 loads.
  - v2 takes v1 when S2 loads.
- Ordering is strictly first-in, first-out; beats are never dropped or duplicated.
- Simultaneous accept and emit with both stages full and out_ready = 1: all three events occur in the same edge, sustaining full throughput.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - v1 and v2.
  - out_valid = 0, diff = 0, err = 0, out_is_gray = 0, err_count = 0.
- With both stages empty during reset, in_ready reads 1.
- Latency: a beat accepted at edge k shows out_valid = 1 after edge k+1, which is 2 cycles from presentation to output.
- Throughput: 1 beat per cycle while out_ready = 1.
- Buffering: with out_ready = 0, the pipe holds 2 beats; in_ready drops after the second beat is accepted.
- Reset mid-operation: in-flight beats are discarded. No output appears for them after rst_n deasserts.
- The first edge after rst_n rises may accept input.
- Boundaries:
  - sum = 0, a = 0 → diff 0, err 0.
  - sum = 2^W − 1 + a → valid maximum, no err.
  - sum = 2^(W+1) − 1, a = 0 → err.

## Configuration
- MAGIC_SUB_ERRCNT_EN defined:
  - err_count increments by 1 on each transfer at the output with err = 1.
  - It saturates at 255 and is cleared only by reset.
- MAGIC_SUB_ERRCNT_EN undefined:
  - The counter logic is not built and err_count is tied to 0.
  - All other behaviour is identical.

## Test plan
- Binary, W = 3: sum = 4'b1010 (10), a = 3'b011, is_gray = 0, out_ready = 1 → diff = 3'b111, err = 0, out_valid 2 cycles after presentation.
- Gray: sum = 4'b1101 (gray 9), a = 3'b110 (gray 4), is_gray = 1 → diff = 3'b111 (gray 5), out_is_gray = 1, err = 0.
- Errors:
  - sum = 4'd2, a = 3'd5 binary → err = 1, diff = 0.
  - sum = 4'd15, a = 0 → err = 1, diff = 0.
  - With MAGIC_SUB_ERRCNT_EN, err_count = 2 after both; 300 error beats leave err_count = 255.
- Backpressure: out_ready = 0, offer beats 10−3, 9−4, 7−7 on consecutive cycles.
  - Required: the first two are accepted, then in_ready = 0 and the third beat stalls.
  - Outputs stay stable while stalled.
  - After out_ready = 1, results emerge in order as 7, 5, 0, one per cycle.
- Streaming: 16 back-to-back random beats with out_ready = 1 → 16 results in order, with no bubbles after the initial 2-cycle latency.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low between edges → out_valid = 0 and err_count = 0 immediately, in_ready = 1, and no stale beat emerges afterward.
